// File: rtl/bitrev_scramble_pkg.sv
// Shared FSM encoding and mode-bit positions for the bit-reverse scrambler.
package bitrev_scramble_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_RD_K,
      ST_RD_J,
      ST_WR_K,
      ST_WR_J,
      ST_DONE
   } state_t;

   localparam int MODE_REV  = 0;
   localparam int MODE_CONJ = 1;

endpackage

// File: rtl/bitrev_scramble_index.sv
// Combinational bit reversal of the low i_log2n bits of an entry index.
module bitrev_index #(
   parameter int LOG2_MAX = 3
) (
   input  logic [LOG2_MAX-1:0] i_idx,
   input  logic [LOG2_MAX:0]   i_log2n,
   output logic [LOG2_MAX-1:0] o_rev
);

   localparam logic [LOG2_MAX:0] C_LOG2_MAX = (LOG2_MAX+1)'(LOG2_MAX);

   logic [LOG2_MAX-1:0] w_full;
   logic [LOG2_MAX:0]   w_shift;

   // Reversing all LOG2_MAX bits, then dropping the unused low end, equals a log2n-bit reversal.
   assign w_full  = {<<{i_idx}};
   assign w_shift = C_LOG2_MAX - i_log2n;
   assign o_rev   = w_full >> w_shift;

endmodule

// File: rtl/bitrev_scramble.sv
// In-place bit-reverse reorder with optional saturating conjugation of a complex RAM buffer.
module bitrev_scramble
   import bitrev_scramble_pkg::*;
#(
   parameter  int WORD_SIZE    = 8,
   parameter  int MAX_FFT_SIZE = 8,
   localparam int LOG2_MAX     = $clog2(MAX_FFT_SIZE),
   localparam int ADDR_SIZE    = $clog2(2*MAX_FFT_SIZE)
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_start,
   input  logic [LOG2_MAX:0]    i_log2n,
   input  logic [1:0]           i_mode,
   input  logic [WORD_SIZE-1:0] i_rddata_A,
   input  logic [WORD_SIZE-1:0] i_rddata_B,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_rden,
   output logic                 o_wren,
   output logic [ADDR_SIZE-1:0] o_rdaddr_A,
   output logic [ADDR_SIZE-1:0] o_rdaddr_B,
   output logic [ADDR_SIZE-1:0] o_wraddr_A,
   output logic [ADDR_SIZE-1:0] o_wraddr_B,
   output logic [WORD_SIZE-1:0] o_wrdata_A,
   output logic [WORD_SIZE-1:0] o_wrdata_B
);

   localparam logic [LOG2_MAX:0]    C_LOG2_MAX  = (LOG2_MAX+1)'(LOG2_MAX);
   localparam logic [WORD_SIZE-1:0] C_MOST_NEG  = {1'b1, {(WORD_SIZE-1){1'b0}}};
   localparam logic [WORD_SIZE-1:0] C_MOST_POS  = {1'b0, {(WORD_SIZE-1){1'b1}}};

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LOG2_MAX-1:0]   r_k;
   logic [LOG2_MAX:0]     r_log2n;
   logic [1:0]            r_mode;
   logic [WORD_SIZE-1:0]  r_cap_re;
   logic [WORD_SIZE-1:0]  r_cap_im;

   logic [LOG2_MAX:0]     w_log2n_clamp;
   logic                  w_trivial;
   logic [LOG2_MAX-1:0]   w_rev;
   logic [LOG2_MAX-1:0]   w_j;
   logic [LOG2_MAX-1:0]   w_kmax;
   logic                  w_last;
   logic                  w_swap;
   logic                  w_fix;

   function automatic logic [WORD_SIZE-1:0] f_conj_im(input logic [WORD_SIZE-1:0] v,
                                                      input logic              conj);
      if (!conj)
         return v;
      if (v == C_MOST_NEG)
         return C_MOST_POS;
      return -v;
   endfunction

   bitrev_index #(.LOG2_MAX(LOG2_MAX)) u_index (
      .i_idx   (r_k),
      .i_log2n (r_log2n),
      .o_rev   (w_rev)
   );

   assign w_log2n_clamp = (i_log2n > C_LOG2_MAX) ? C_LOG2_MAX : i_log2n;
   assign w_trivial     = (w_log2n_clamp == '0) || (i_mode == 2'b00);
   assign w_j           = r_mode[MODE_REV] ? w_rev : r_k;
   assign w_kmax        = LOG2_MAX'((1 << r_log2n) - 1);
   assign w_last        = (r_k == w_kmax);
   assign w_swap        = (w_j > r_k);
   assign w_fix         = (w_j == r_k) && r_mode[MODE_CONJ];

   // NOTE: every output and next-state term gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_rden      = 1'b0;
      o_wren      = 1'b0;
      o_rdaddr_A  = '0;
      o_rdaddr_B  = '0;
      o_wraddr_A  = '0;
      o_wraddr_B  = '0;
      o_wrdata_A  = '0;
      o_wrdata_B  = '0;
      case (r_state)
         ST_IDLE: begin
            if (i_start)
               w_state_nxt = w_trivial ? ST_DONE : ST_SCAN;
         end
         ST_SCAN: begin
            o_busy = 1'b1;
            if (w_swap || w_fix)
               w_state_nxt = ST_RD_K;
            else
               w_state_nxt = w_last ? ST_DONE : ST_SCAN;
         end
         ST_RD_K: begin
            o_busy      = 1'b1;
            o_rden      = 1'b1;
            o_rdaddr_A  = {r_k, 1'b0};
            o_rdaddr_B  = {r_k, 1'b1};
            w_state_nxt = w_swap ? ST_RD_J : ST_WR_K;
         end
         ST_RD_J: begin
            o_busy      = 1'b1;
            o_rden      = 1'b1;
            o_rdaddr_A  = {w_j, 1'b0};
            o_rdaddr_B  = {w_j, 1'b1};
            w_state_nxt = ST_WR_K;
         end
         ST_WR_K: begin
            // Data of the most recent read (j for a swap, k for a fixed point) is on the bus now.
            o_busy      = 1'b1;
            o_wren      = 1'b1;
            o_wraddr_A  = {r_k, 1'b0};
            o_wraddr_B  = {r_k, 1'b1};
            o_wrdata_A  = i_rddata_A;
            o_wrdata_B  = f_conj_im(i_rddata_B, r_mode[MODE_CONJ]);
            if (w_swap)
               w_state_nxt = ST_WR_J;
            else
               w_state_nxt = w_last ? ST_DONE : ST_SCAN;
         end
         ST_WR_J: begin
            o_busy      = 1'b1;
            o_wren      = 1'b1;
            o_wraddr_A  = {w_j, 1'b0};
            o_wraddr_B  = {w_j, 1'b1};
            o_wrdata_A  = r_cap_re;
            o_wrdata_B  = f_conj_im(r_cap_im, r_mode[MODE_CONJ]);
            w_state_nxt = w_last ? ST_DONE : ST_SCAN;
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_log2n  <= '0;
         r_mode   <= '0;
         r_cap_re <= '0;
         r_cap_im <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE) begin
            r_k <= '0;
            if (i_start) begin
               r_log2n <= w_log2n_clamp;
               r_mode  <= i_mode;
            end
         end else if (w_state_nxt == ST_SCAN) begin
            r_k <= r_k + 1'b1;
         end
         if (r_state == ST_RD_J) begin
            r_cap_re <= i_rddata_A;
            r_cap_im <= i_rddata_B;
         end
      end
   end

endmodule

// File: tb/tb_bitrev_scramble.sv
// Self-checking bench: RAM model, per-cycle handshake/protocol compare, and an array-level result model.
module tb_bitrev_scramble;

   localparam int W  = 8;
   localparam int L2 = 3;
   localparam int AW = 4;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [L2:0]   i_log2n = '0;
   logic [1:0]    i_mode = '0;
   logic [W-1:0]  rd_A = '0;
   logic [W-1:0]  rd_B = '0;
   logic          o_busy, o_done, o_rden, o_wren;
   logic [AW-1:0] o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B;
   logic [W-1:0]  o_wrdata_A, o_wrdata_B;

   logic [W-1:0]  mem      [NW];
   logic [W-1:0]  load_img [NW];
   logic [W-1:0]  exp_img  [NW];
   logic          load_req = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit run_active = 1'b0;
   int run_m = 0;
   int run_lat = 0;
   int run_n = 0;
   int acc_count = 0;
   bit exp_done, exp_busy;
   bit found;

   always #5 clk = ~clk;

   bitrev_scramble #(.WORD_SIZE(W), .MAX_FFT_SIZE(8)) dut (
      .i_CLK      (clk),
      .i_RST      (rst_n),
      .i_start    (i_start),
      .i_log2n    (i_log2n),
      .i_mode     (i_mode),
      .i_rddata_A (rd_A),
      .i_rddata_B (rd_B),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_rden     (o_rden),
      .o_wren     (o_wren),
      .o_rdaddr_A (o_rdaddr_A),
      .o_rdaddr_B (o_rdaddr_B),
      .o_wraddr_A (o_wraddr_A),
      .o_wraddr_B (o_wraddr_B),
      .o_wrdata_A (o_wrdata_A),
      .o_wrdata_B (o_wrdata_B)
   );

   // RAM: read issued in cycle t is presented during t+1.
   always @(posedge clk) begin
      if (load_req)
         mem <= load_img;
      else if (o_wren) begin
         mem[o_wraddr_A] <= o_wrdata_A;
         mem[o_wraddr_B] <= o_wrdata_B;
      end
      if (o_rden) begin
         rd_A <= mem[o_rdaddr_A];
         rd_B <= mem[o_rdaddr_B];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int bitrev(input int k, input int l);
      int r = 0;
      for (int b = 0; b < l; b++)
         r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
      int x = -int'($signed(v));
      if (x > 127)
         x = 127;
      return W'(x);
   endfunction

   task automatic model_run(input int log2n, input int mode);
      int l = (log2n > L2) ? L2 : log2n;
      int n = 1 << l;
      int s = 0;
      int f = 0;
      int j;
      bit rev  = (mode % 2) == 1;
      bit conj = mode >= 2;
      exp_img = load_img;
      run_n = n;
      if (l == 0 || mode == 0) begin
         run_lat = 1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         j = rev ? bitrev(k, l) : k;
         if (j > k)
            s++;
         else if (j == k && conj)
            f++;
         exp_img[2*k]   = load_img[2*j];
         exp_img[2*k+1] = conj ? neg_sat(load_img[2*j+1]) : load_img[2*j+1];
      end
      run_lat = n + 4*s + 2*f + 1;
   endtask

   // Per-cycle compare: handshake timeline against the model latency, plus RAM-access protocol.
   always @(negedge clk) begin
      if (rst_n) begin
         check("rd_wr_exclusive", 32'(o_rden & o_wren), 32'd0);
         if (run_active) begin
            if (o_rden) begin
               check("rd_addr_range", 32'(int'(o_rdaddr_A) < 2*run_n), 32'd1);
               check("rd_addr_pair", 32'(o_rdaddr_A[0] == 1'b0 && o_rdaddr_B == o_rdaddr_A + 1'b1), 32'd1);
            end
            if (o_wren) begin
               check("wr_addr_range", 32'(int'(o_wraddr_A) < 2*run_n), 32'd1);
               check("wr_addr_pair", 32'(o_wraddr_A[0] == 1'b0 && o_wraddr_B == o_wraddr_A + 1'b1), 32'd1);
            end
            if (o_rden || o_wren)
               acc_count++;
            exp_done = (run_m == run_lat - 1);
            exp_busy = (run_m <  run_lat - 1);
            check($sformatf("done@%0d", run_m), 32'(o_done), 32'(exp_done));
            check($sformatf("busy@%0d", run_m), 32'(o_busy), 32'(exp_busy));
            if (exp_done)
               run_active = 1'b0;
            run_m++;
         end else begin
            check("idle_outputs", 32'({o_busy, o_done, o_rden, o_wren}), 32'd0);
         end
      end
   end

   task automatic load_default();
      for (int k = 0; k < 8; k++) begin
         load_img[2*k]   = W'(k);
         load_img[2*k+1] = W'(8'h10 + k);
      end
   endtask

   task automatic do_load();
      @(negedge clk); #1;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic run(input int log2n, input int mode, input int restart_at);
      model_run(log2n, mode);
      acc_count = 0;
      @(negedge clk); #1;
      i_log2n    = (L2+1)'(log2n);
      i_mode     = 2'(mode);
      i_start    = 1'b1;
      run_m      = 0;
      run_active = 1'b1;
      for (int c = 0; c < 400 && run_active; c++) begin
         @(posedge clk); #1;
         i_start = (c + 1 == restart_at);
      end
      i_start = 1'b0;
      if (run_active) begin
         check("run_timeout", run_m, run_lat);
         run_active = 1'b0;
      end
      for (int w = 0; w < NW; w++)
         check($sformatf("ram[%0d]", w), mem[w], exp_img[w]);
      if (run_lat == 1)
         check("no_ram_access", acc_count, 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, 32'({o_busy, o_done, o_rden, o_wren}), 32'd0);
      check({name, "_addr"}, {16'd0, o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B}, 32'd0);
      check({name, "_data"}, {16'd0, o_wrdata_A, o_wrdata_B}, 32'd0);
   endtask

   initial begin
      #3;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // N=8 bit-reverse only
      load_default(); do_load();
      run(3, 1, -1);
      check("lat_n8_rev", run_lat, 17);
      check("t1_e1_re", mem[2], 8'h04);
      check("t1_e1_im", mem[3], 8'h14);
      check("t1_e4_re", mem[8], 8'h01);
      check("t1_e4_im", mem[9], 8'h11);
      check("t1_e3_re", mem[6], 8'h06);
      check("t1_e6_im", mem[13], 8'h13);
      check("t1_e0_im", mem[1], 8'h10);

      // N=8 bit-reverse plus conjugate
      load_default(); do_load();
      run(3, 3, -1);
      check("lat_n8_rev_conj", run_lat, 25);
      check("t2_e0_im", mem[1], 8'hF0);
      check("t2_e1_re", mem[2], 8'h04);
      check("t2_e1_im", mem[3], 8'hEC);

      // Conjugate only, with the most-negative value saturating
      load_default(); load_img[5] = 8'h80; do_load();
      run(3, 2, -1);
      check("lat_n8_conj", run_lat, 25);
      check("t3_e2_im", mem[5], 8'h7F);
      check("t3_e2_re", mem[4], 8'h02);
      check("t3_e1_im", mem[3], 8'hEF);

      // N=4: only entries 1 and 2 swap, upper half untouched
      load_default(); do_load();
      run(2, 1, -1);
      check("lat_n4_rev", run_lat, 9);
      check("t4_e1_re", mem[2], 8'h02);
      check("t4_e1_im", mem[3], 8'h12);
      check("t4_e2_re", mem[4], 8'h01);
      check("t4_e2_im", mem[5], 8'h11);
      check("t4_e4_re", mem[8], 8'h04);

      // Oversized log2n clamps to the largest supported size
      load_default(); do_load();
      run(15, 1, -1);
      check("t5_clamp_e1_re", mem[2], 8'h04);

      // Second start pulse mid-run is ignored
      load_default(); do_load();
      run(3, 1, 4);

      // Degenerate requests: immediate done, no RAM traffic
      load_default(); do_load();
      run(3, 0, -1);
      run(0, 3, -1);

      // Reset during WR_J aborts at once; a fresh run then completes
      load_default(); do_load();
      model_run(3, 1);
      @(negedge clk); #1;
      i_log2n = 4'd3; i_mode = 2'b01; i_start = 1'b1;
      run_m = 0; run_active = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk); #1;
         found = o_wren && (o_wraddr_A == AW'(8));
      end
      check("reach_wr_j", 32'(found), 32'd1);
      run_active = 1'b0;
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk); #1;
      rst_n = 1'b1;
      load_default(); do_load();
      run(3, 1, -1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
